// File: rtl/minisrc_pkg.sv
// Shared definitions for the Mini SRC control-step sequencer: opcodes,
// bus source indices, sequencer states and the opcode classifier.
package minisrc_pkg;

  localparam int unsigned MEM_WAIT_MAX_DEFAULT = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int unsigned BUS_R0     = 0;
  localparam int unsigned BUS_R15    = 15;
  localparam int unsigned BUS_HI     = 16;
  localparam int unsigned BUS_LO     = 17;
  localparam int unsigned BUS_ZHIGH  = 18;
  localparam int unsigned BUS_ZLOW   = 19;
  localparam int unsigned BUS_PC     = 20;
  localparam int unsigned BUS_MDR    = 21;
  localparam int unsigned BUS_INPORT = 22;
  localparam int unsigned BUS_C      = 23;
  localparam int unsigned BUS_W      = 24;

  // ST_ABORT is the single-cycle memory-timeout report step.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_ABORT
  } state_e;

  typedef enum logic [1:0] {
    CLS_BINARY,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_BINARY;
      OP_MUL, OP_DIV:                  cls = CLS_MULDIV;
      OP_NEG, OP_NOT:                  cls = CLS_UNARY;
      default:                         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/minisrc_reg_decode.sv
// 4-bit register index plus enable to 16-bit one-hot select.
module minisrc_reg_decode
  import minisrc_pkg::*;
(
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // At most one bit set, none when disabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/minisrc_step_sequencer.sv
// Mini SRC control-step sequencer: fetch then execute of register-form
// ALU, mul/div and unary instructions, one T-step per clock. Sole owner
// of the bus source selects, so at most one bus driver per cycle.
// Optional SEQ_SINGLE_STEP_EN adds a step_en input gating every advance.
module minisrc_step_sequencer
  import minisrc_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step_en,
`endif
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic [23:0] bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_class_e  cls;
  logic       advance;

  logic [7:0]  bus_hi;
  logic [3:0]  bus_reg_idx;
  logic        bus_reg_en;
  logic [15:0] bus_reg_oh;
  logic        reg_we;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[14:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = step_en;
`else
  assign advance = 1'b1;
`endif

  // State and T1 wait-counter registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state: step sequencing, memory wait and timeout in T1.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (advance) begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_T0;
        ST_T0: begin
          state_d    = ST_T1;
          wait_cnt_d = '0;
        end
        ST_T1: begin
          if (mem_done)                     state_d = ST_T2;
          else if (wait_cnt_q == CNT_LAST)  state_d = ST_ABORT;
          else                              wait_cnt_d = wait_cnt_q + 1'b1;
        end
        ST_T2:    state_d = ST_T3;
        ST_T3:    state_d = (cls == CLS_ILLEGAL) ? ST_IDLE : ST_T4;
        ST_T4:    state_d = (cls == CLS_UNARY)   ? ST_IDLE : ST_T5;
        ST_T5:    state_d = (cls == CLS_MULDIV)  ? ST_T6   : ST_IDLE;
        ST_T6:    state_d = ST_IDLE;
        ST_ABORT: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: decoded from the registered state (plus the latched IR).
  always_comb begin
    bus_hi      = '0;
    bus_reg_idx = '0;
    bus_reg_en  = 1'b0;
    reg_we      = 1'b0;
    pc_in       = 1'b0;
    ir_in       = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    inc_pc      = 1'b0;
    read        = 1'b0;
    alu_op      = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      ST_T0: begin
        bus_hi[BUS_PC - BUS_HI] = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      ST_T1: begin
        bus_hi[BUS_ZLOW - BUS_HI] = 1'b1;
        pc_in  = 1'b1;
        read   = 1'b1;
        mdr_in = mem_done;
      end
      ST_T2: begin
        bus_hi[BUS_MDR - BUS_HI] = 1'b1;
        ir_in = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_BINARY: begin
            bus_reg_idx = rb;
            bus_reg_en  = 1'b1;
            y_in        = 1'b1;
          end
          CLS_MULDIV: begin
            bus_reg_idx = ra;
            bus_reg_en  = 1'b1;
            y_in        = 1'b1;
          end
          CLS_UNARY: begin
            bus_reg_idx = rb;
            bus_reg_en  = 1'b1;
            alu_op      = opcode;
            z_in        = 1'b1;
          end
          default: begin
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_BINARY: begin
            bus_reg_idx = rc;
            bus_reg_en  = 1'b1;
            alu_op      = opcode;
            z_in        = 1'b1;
          end
          CLS_MULDIV: begin
            bus_reg_idx = rb;
            bus_reg_en  = 1'b1;
            alu_op      = opcode;
            z_in        = 1'b1;
          end
          CLS_UNARY: begin
            bus_hi[BUS_ZLOW - BUS_HI] = 1'b1;
            reg_we = 1'b1;
            done   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        bus_hi[BUS_ZLOW - BUS_HI] = 1'b1;
        if (cls == CLS_MULDIV) begin
          lo_in = 1'b1;
        end else begin
          reg_we = 1'b1;
          done   = 1'b1;
        end
      end
      ST_T6: begin
        bus_hi[BUS_ZHIGH - BUS_HI] = 1'b1;
        hi_in = 1'b1;
        done  = 1'b1;
      end
      ST_ABORT: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  minisrc_reg_decode u_bus_dec (
    .idx    (bus_reg_idx),
    .en     (bus_reg_en),
    .onehot (bus_reg_oh)
  );

  minisrc_reg_decode u_wr_dec (
    .idx    (ra),
    .en     (reg_we),
    .onehot (reg_in)
  );

  assign bus_sel = {bus_hi, bus_reg_oh};

endmodule

// File: tb/tb_minisrc_step_sequencer.sv
// Directed bench for minisrc_step_sequencer (default MEM_WAIT_MAX = 15).
module tb_minisrc_step_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  logic        mem_done;
  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        inc_pc, read, busy, done, illegal;
  logic [4:0]  alu_op;
  logic [12:0] strb;

  int nvec = 0;
  int nerr = 0;
  int acc  = 0;
  int ndone = 0;

  localparam logic [12:0] P_PC_IN = 13'h1000, P_IR_IN = 13'h0800, P_MAR = 13'h0400,
                          P_MDR   = 13'h0200, P_Y     = 13'h0100, P_Z   = 13'h0080,
                          P_HI    = 13'h0040, P_LO    = 13'h0020, P_INC = 13'h0010,
                          P_RD    = 13'h0008, P_BUSY  = 13'h0004, P_DONE = 13'h0002,
                          P_ILL   = 13'h0001;

  localparam logic [23:0] B_HI = 24'h010000, B_LO = 24'h020000, B_ZHI = 24'h040000,
                          B_ZLO = 24'h080000, B_PC = 24'h100000, B_MDR = 24'h200000;

  assign strb = {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in,
                 inc_pc, read, busy, done, illegal};

  minisrc_step_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step_en  (1'b1),
`endif
    .ir       (ir),
    .mem_done (mem_done),
    .bus_sel  (bus_sel),
    .reg_in   (reg_in),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .mar_in   (mar_in),
    .mdr_in   (mdr_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .inc_pc   (inc_pc),
    .read     (read),
    .alu_op   (alu_op),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_step(input string tag, input logic [23:0] b, input logic [15:0] r,
                             input logic [4:0] a, input logic [12:0] s);
    #1;
    chk({tag, ".bus_sel"}, 32'(bus_sel), 32'(b));
    chk({tag, ".reg_in"},  32'(reg_in),  32'(r));
    chk({tag, ".alu_op"},  32'(alu_op),  32'(a));
    chk({tag, ".strobes"}, 32'(strb),    32'(s));
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Launch one instruction; leaves the DUT in T0 at a falling edge.
  task automatic launch(input logic [31:0] instr, input logic md);
    ir = instr;
    mem_done = md;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    ir = '0;
    mem_done = 1'b0;
    tick;
    expect_step("reset", '0, '0, '0, '0);
    clear = 1'b0;
    tick;
    expect_step("idle", '0, '0, '0, '0);

    // add r4 = r7 + r8, start pulsed again during T1 (must be ignored)
    launch(32'h1A3C0000, 1'b1);
    expect_step("add.T0", B_PC, '0, '0, P_MAR | P_INC | P_Z | P_BUSY);
    tick;
    expect_step("add.T1", B_ZLO, '0, '0, P_PC_IN | P_RD | P_MDR | P_BUSY);
    start = 1'b1;
    tick;
    expect_step("add.T2", B_MDR, '0, '0, P_IR_IN | P_BUSY);
    start = 1'b0;
    tick;
    expect_step("add.T3", 24'h000080, '0, '0, P_Y | P_BUSY);
    tick;
    expect_step("add.T4", 24'h000100, '0, 5'b00011, P_Z | P_BUSY);
    tick;
    expect_step("add.T5", B_ZLO, 16'h0010, '0, P_DONE | P_BUSY);
    tick;
    expect_step("add.idle", '0, '0, '0, '0);

    // mul r2, r3
    launch(32'h79180000, 1'b1);
    expect_step("mul.T0", B_PC, '0, '0, P_MAR | P_INC | P_Z | P_BUSY);
    tick; tick; tick;
    expect_step("mul.T3", 24'h000004, '0, '0, P_Y | P_BUSY);
    tick;
    expect_step("mul.T4", 24'h000008, '0, 5'b01111, P_Z | P_BUSY);
    tick;
    expect_step("mul.T5", B_ZLO, '0, '0, P_LO | P_BUSY);
    tick;
    expect_step("mul.T6", B_ZHI, '0, '0, P_HI | P_DONE | P_BUSY);
    tick;
    expect_step("mul.idle", '0, '0, '0, '0);

    // neg r5 = -r9
    launch(32'h8AC80000, 1'b1);
    tick; tick; tick;
    expect_step("neg.T3", 24'h000200, '0, 5'b10001, P_Z | P_BUSY);
    tick;
    expect_step("neg.T4", B_ZLO, 16'h0020, '0, P_DONE | P_BUSY);
    tick;
    expect_step("neg.idle", '0, '0, '0, '0);

    // memory wait: mem_done low for 3 T1 cycles, high in the 4th
    launch(32'h1A3C0000, 1'b0);
    expect_step("wait.T0", B_PC, '0, '0, P_MAR | P_INC | P_Z | P_BUSY);
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_done = 1'b1;
        expect_step("wait.T1last", B_ZLO, '0, '0, P_PC_IN | P_RD | P_MDR | P_BUSY);
      end else begin
        expect_step("wait.T1", B_ZLO, '0, '0, P_PC_IN | P_RD | P_BUSY);
      end
      tick;
    end
    expect_step("wait.T2", B_MDR, '0, '0, P_IR_IN | P_BUSY);
    tick; tick; tick;
    expect_step("wait.T5", B_ZLO, 16'h0010, '0, P_DONE | P_BUSY);
    tick;

    // boundary: mem_done arrives in the 15th T1 cycle, still accepted
    launch(32'h1A3C0000, 1'b0);
    tick;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        mem_done = 1'b1;
        expect_step("edge.T1last", B_ZLO, '0, '0, P_PC_IN | P_RD | P_MDR | P_BUSY);
      end
      tick;
    end
    expect_step("edge.T2", B_MDR, '0, '0, P_IR_IN | P_BUSY);
    tick; tick; tick; tick;
    expect_step("edge.idle", '0, '0, '0, '0);

    // timeout: no mem_done for 15 T1 cycles
    launch(32'h1A3C0000, 1'b0);
    tick;
    for (int i = 0; i < 15; i++) begin
      expect_step("tmo.T1", B_ZLO, '0, '0, P_PC_IN | P_RD | P_BUSY);
      tick;
    end
    expect_step("tmo.abort", '0, '0, '0, P_ILL | P_DONE | P_BUSY);
    tick;
    expect_step("tmo.idle", '0, '0, '0, '0);

    // unsupported opcode 11111
    launch(32'hF8000000, 1'b1);
    tick; tick; tick;
    expect_step("ill.T3", '0, '0, '0, P_ILL | P_DONE | P_BUSY);
    tick;
    expect_step("ill.idle", '0, '0, '0, '0);

    // clear in T4 of an add: outputs drop immediately, no write afterwards
    launch(32'h1A3C0000, 1'b1);
    tick; tick; tick; tick;
    expect_step("clr.T4", 24'h000100, '0, 5'b00011, P_Z | P_BUSY);
    #1;
    clear = 1'b1;
    expect_step("clr.async", '0, '0, '0, '0);
    tick;
    expect_step("clr.held", '0, '0, '0, '0);
    clear = 1'b0;
    tick;
    expect_step("clr.after", '0, '0, '0, '0);

    // random traffic: one-hot invariants and one done per accepted start
    for (int c = 0; c < 10000; c++) begin
      tick;
      #1;
      chk("inv.bus_onehot", 32'($countones(bus_sel) <= 1), 32'd1);
      chk("inv.reg_onehot", 32'($countones(reg_in) <= 1), 32'd1);
      if (done) ndone++;
      if (!busy) ir = {5'($urandom_range(0, 31)), 27'($urandom)};
      start = ($urandom_range(0, 2) == 0);
      if (start && !busy) acc++;
      mem_done = ($urandom_range(0, 4) != 0);
    end
    start = 1'b0;
    mem_done = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick;
      #1;
      if (done) ndone++;
      if (!busy) break;
    end
    chk("drain.busy", 32'(busy), 32'd0);
    chk("rand.done_count", 32'(ndone), 32'(acc));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
